// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential pc, combinational-read imem, and a 2-entry
// {instr, pc} queue feeding decode, with redirect, halt and misalignment trapping.
module instr_fetch_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_W_IMEM = 12,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDR_W_IMEM-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]  imem_instr,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    input  logic                   halt_req,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_instr,
    output logic [31:0]            out_pc,
    output logic                   fetch_err
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e                state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] instr_q [2];
    logic [31:0]           epc_q   [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q;
    logic                  push, pop, flush, misaligned;

    // Redirects are ignored while IDLE; otherwise they beat halt_req and push.
    always_comb begin
        pop        = (count_q != 2'd0) && out_ready;
        flush      = redirect_valid && (state_q != StIdle);
        misaligned = flush && (redirect_pc[1:0] != 2'b00);
        push       = (state_q == StRun) && !redirect_valid && !halt_req &&
                     ((count_q != 2'd2) || pop);
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q | misaligned;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle:  state_d = StRun;
            StRun:   if (halt_req) state_d = StHalt;
            StHalt:  if (!halt_req && !err_q) state_d = StRun;
            default: state_d = StIdle;
        endcase
        if (misaligned) state_d = StHalt;
        if (flush) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            err_q    <= 1'b0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                epc_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            if (flush) begin
                count_q  <= 2'd0;
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    instr_q[wr_ptr_q] <= imem_instr;
                    epc_q[wr_ptr_q]   <= pc_q;
                    wr_ptr_q          <= ~wr_ptr_q;
                end
                if (pop) rd_ptr_q <= ~rd_ptr_q;
                count_q <= count_q + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    always_comb begin
        imem_addr = pc_q[ADDR_W_IMEM-1:0];
        out_valid = (count_q != 2'd0);
        out_instr = instr_q[rd_ptr_q];
        out_pc    = epc_q[rd_ptr_q];
        fetch_err = err_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of expected {pc, instr}
// pairs checked on every accepted output, plus per-scenario inline checks.
module tb_instr_fetch_unit;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_instr;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          halt_req;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic          fetch_err;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    instr_fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_W_IMEM(AW),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    // Memory word i holds 0x1000_0000 + i.
    assign imem_instr = 32'h1000_0000 + {22'd0, imem_addr[AW-1:2]};

    // Scoreboard: every accepted output must match the next expected pair.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pop pc=%h instr=%h", out_pc, out_instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({out_pc, out_instr} !== e) begin
                    errors++;
                    $display("FAIL sb_pop got pc=%h instr=%h want pc=%h instr=%h",
                             out_pc, out_instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] pc0, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] p;
            p = pc0 + 32'(4 * i);
            exp_q.push_back({p, 32'h1000_0000 + {22'd0, p[AW-1:2]}});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt_req = 1'b0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", fetch_err); end
        if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", out_instr); end
        if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", out_pc); end
        if (imem_addr !== 12'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid got %b want 0", out_valid); end
    endtask

    task automatic test_stream();
        exp_q.delete();
        push_seq(32'h0, 40);
        out_ready = 1'b1;
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle got %b want 0", out_valid); end
        step();
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid got %b want 1", out_valid); end
        if ({out_pc, out_instr} !== {32'h0, 32'h1000_0000}) begin
            errors++;
            $display("FAIL stream_first got pc=%h instr=%h want 0/10000000", out_pc, out_instr);
        end
        for (int k = 1; k < 10; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stream_seq got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, 4 * k);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] head_pc;
        int sz;
        head_pc = exp_q[0][63:32];
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== head_pc) begin
                errors++;
                $display("FAIL bp_head got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, head_pc);
            end
        end
        checks += 2;
        if (dut.count_q !== 2'd2) begin errors++; $display("FAIL bp_count got %0d want 2", dut.count_q); end
        if (imem_addr !== 12'(head_pc + 32'd8)) begin
            errors++;
            $display("FAIL bp_pc got %h want %h", imem_addr, 12'(head_pc + 32'd8));
        end
        sz = exp_q.size();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (sz - exp_q.size() != 8) begin
            errors++;
            $display("FAIL bp_drain got %0d pops want 8", sz - exp_q.size());
        end
    endtask

    task automatic test_redirect();
        out_ready = 1'b0;
        exp_q.delete();
        push_seq(32'h40, 8);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", out_valid); end
        if (imem_addr !== 12'h040) begin errors++; $display("FAIL redir_addr got %h want 040", imem_addr); end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h40, 32'h1000_0010}) begin
            errors++;
            $display("FAIL redir_first got v=%b pc=%h instr=%h want 1/40/10000010", out_valid, out_pc, out_instr);
        end
        step();
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h44, 32'h1000_0011}) begin
            errors++;
            $display("FAIL redir_second got v=%b pc=%h instr=%h want 1/44/10000011", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        exp_q.delete();
        exp_q.push_back({32'hFFC, 32'h1000_03FF});
        push_seq(32'h1000, 6);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFC;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== 12'hFFC) begin errors++; $display("FAIL wrap_addr0 got %h want ffc", imem_addr); end
        out_ready = 1'b1;
        step();
        checks += 2;
        if (imem_addr !== 12'h000) begin errors++; $display("FAIL wrap_addr1 got %h want 000", imem_addr); end
        if ({out_pc, out_instr} !== {32'hFFC, 32'h1000_03FF}) begin
            errors++;
            $display("FAIL wrap_out0 got pc=%h instr=%h want ffc/100003ff", out_pc, out_instr);
        end
        step();
        checks++;
        if ({out_pc, out_instr} !== {32'h1000, 32'h1000_0000}) begin
            errors++;
            $display("FAIL wrap_out1 got pc=%h instr=%h want 1000/10000000", out_pc, out_instr);
        end
    endtask

    task automatic test_midreset();
        out_ready = 1'b0;
        exp_q.delete();
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b want 0", out_valid); end
        if (imem_addr !== 12'h000) begin errors++; $display("FAIL mrst_addr got %h want 000", imem_addr); end
        push_seq(32'h0, 8);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_idle got %b want 0", out_valid); end
        step();
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, 32'h1000_0000}) begin
            errors++;
            $display("FAIL mrst_restart got v=%b pc=%h instr=%h want 1/0/10000000", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_misaligned();
        out_ready = 1'b0;
        exp_q.delete();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h22;
        step();
        redirect_valid = 1'b0;
        checks += 3;
        if (fetch_err !== 1'b1) begin errors++; $display("FAIL mis_err got %b want 1", fetch_err); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mis_valid got %b want 0", out_valid); end
        if (imem_addr !== 12'h020) begin errors++; $display("FAIL mis_pc got %h want 020", imem_addr); end
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || imem_addr !== 12'h020 || fetch_err !== 1'b1) begin
                errors++;
                $display("FAIL mis_stuck got v=%b addr=%h err=%b want 0/020/1", out_valid, imem_addr, fetch_err);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (fetch_err !== 1'b0) begin errors++; $display("FAIL mis_reset got %b want 0", fetch_err); end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_midreset();
        test_misaligned();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
